// File: rtl/reflex_pkg.sv
// Shared types and constants for the reflex trainer round controller.
package reflex_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GO   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int MS_W           = 14;
  localparam int DEF_TIMEOUT_MS = 9999;
  localparam int DEF_MS_DIV     = 100000;

  // x^16+x^14+x^13+x^11+1, right-shifting form: taps counted from the output bit 0
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/reflex_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; reloads SEED on reset.
module reflex_lfsr16
  import reflex_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) r_q <= SEED;
    else     r_q <= {^(r_q & LFSR_TAPS), r_q[15:1]};
  end

  assign q = r_q;

endmodule

// File: rtl/reflex_round_ctrl.sv
// Reflex trainer round controller: random wait in game seconds, GO, ms reaction timing.
// Optional best-score tracking enabled by defining REFLEX_BEST_SCORE_EN.
module reflex_round_ctrl
  import reflex_pkg::*;
#(
  parameter int          MS_DIV     = DEF_MS_DIV,
  parameter int          MIN_WAIT_S = 1,
  parameter int          WAIT_BITS  = 2,
  parameter int          TIMEOUT_MS = DEF_TIMEOUT_MS,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            hit,
  input  logic            sec_tick,
  output logic            sec_en,
  output logic            go_led,
  output logic            busy,
  output logic            result_valid,
  output logic [MS_W-1:0] result_ms,
  output logic            foul,
  output logic            timeout
`ifdef REFLEX_BEST_SCORE_EN
  ,
  output logic [MS_W-1:0] best_ms,
  output logic            new_best
`endif
);

  localparam int WAIT_W = $clog2(MIN_WAIT_S + 2**WAIT_BITS) + 1;
  localparam int PRE_W  = $clog2(MS_DIV) + 1;

  state_e            r_state, w_next;
  logic [15:0]       w_lfsr;
  logic              w_unused_lfsr;
  logic [WAIT_W-1:0] r_wait;
  logic [PRE_W-1:0]  r_pre;
  logic [MS_W-1:0]   r_ms;
  logic [MS_W-1:0]   w_res;
  logic              w_wrap, w_cap;
  logic              w_arm, w_go_enter, w_foul, w_hit_go, w_to;

  reflex_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:WAIT_BITS];

  // w_cap marks the cycle whose prescaler wrap would take ms_cnt to TIMEOUT_MS
  assign w_wrap = (r_pre == PRE_W'(MS_DIV - 1));
  assign w_cap  = w_wrap && (r_ms == MS_W'(TIMEOUT_MS - 1));
  assign w_res  = w_cap ? MS_W'(TIMEOUT_MS) : r_ms;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_arm      = 1'b0;
    w_go_enter = 1'b0;
    w_foul     = 1'b0;
    w_hit_go   = 1'b0;
    w_to       = 1'b0;
    sec_en     = 1'b0;
    go_led     = 1'b0;
    busy       = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next = ARM;
          w_arm  = 1'b1;
        end
      end
      ARM: begin
        sec_en = 1'b1;
        busy   = 1'b1;
        if (hit) begin
          w_next = DONE;
          w_foul = 1'b1;
        end else if (sec_tick && (r_wait <= WAIT_W'(1))) begin
          w_next     = GO;
          w_go_enter = 1'b1;
        end
      end
      GO: begin
        go_led = 1'b1;
        busy   = 1'b1;
        if (hit) begin
          w_next   = DONE;
          w_hit_go = 1'b1;
        end else if (w_cap) begin
          w_next = DONE;
          w_to   = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait       <= '0;
      r_pre        <= '0;
      r_ms         <= '0;
      result_valid <= 1'b0;
      result_ms    <= '0;
      foul         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      result_valid <= w_foul | w_hit_go | w_to;
      if (w_arm) begin
        r_wait  <= WAIT_W'(MIN_WAIT_S) + WAIT_W'(w_lfsr[WAIT_BITS-1:0]);
        foul    <= 1'b0;
        timeout <= 1'b0;
      end else if (sec_en && sec_tick) begin
        r_wait <= r_wait - WAIT_W'(1);
      end
      if (w_go_enter) begin
        r_pre <= '0;
        r_ms  <= '0;
      end else if (go_led) begin
        r_pre <= w_wrap ? '0 : r_pre + PRE_W'(1);
        if (w_wrap) r_ms <= r_ms + MS_W'(1);
      end
      if (w_foul) foul <= 1'b1;
      if (w_hit_go) result_ms <= w_res;
      if (w_to) begin
        result_ms <= MS_W'(TIMEOUT_MS);
        timeout   <= 1'b1;
      end
    end
  end

`ifdef REFLEX_BEST_SCORE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      best_ms  <= 14'h3FFF;
      new_best <= 1'b0;
    end else begin
      new_best <= 1'b0;
      if (w_hit_go && (w_res < best_ms)) begin
        best_ms  <= w_res;
        new_best <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/reflex_round_ctrl.md
Name: reflex_round_ctrl

Overview:
- Round controller for the reflex trainer; sits directly downstream of the 1-second game clock divisor and consumes its one-cycle tick.
- Drives that divisor's start/enable input.
- Per round: waits a pseudo-random whole number of game seconds, lights the GO indicator, then measures player reaction in milliseconds.
- Reports the result, a false start, or a timeout to the display/score logic.

Parameters:
- MS_DIV, 100000: clk cycles per millisecond (100 MHz).
- MIN_WAIT_S, 1: minimum seconds before GO.
- WAIT_BITS, 2: random extra wait is 0..2^WAIT_BITS-1 seconds.
- TIMEOUT_MS, 9999: reaction cap in ms; must be < 2^14.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse (debounced): begin round
- hit  in  1  one-cycle pulse (debounced): player button
- sec_tick  in  1  one-cycle pulse from the game clock divisor, once per game second
- sec_en  out  1  start/enable to the game clock divisor; high only in ARM
- go_led  out  1  GO indicator
- busy  out  1  high in ARM or GO
- result_valid  out  1  one-cycle pulse: result_ms updated
- result_ms  out  14  last reaction time in ms, binary
- foul  out  1  level: last round ended by early hit
- timeout  out  1  level: last round hit TIMEOUT_MS

Behaviour:
- Reset values:
  - Outputs: sec_en=0, go_led=0, busy=0, result_valid=0, result_ms=0, foul=0, timeout=0.
  - Internal: FSM=IDLE, LFSR=LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-runs every cycle, including IDLE.
- States: IDLE, ARM, GO, DONE.
- IDLE or DONE, start=1 -> ARM:
  - wait_cnt <= MIN_WAIT_S + LFSR[WAIT_BITS-1:0], sampled that cycle.
  - Clear foul and timeout.
- ARM:
  - sec_en=1.
  - Each sec_tick decrements wait_cnt; the tick that makes it 0 -> GO on the next cycle.
  - hit in ARM -> DONE with foul=1, result_ms unchanged, result_valid=1. Hit takes priority over a simultaneous final sec_tick.
- GO:
  - go_led=1.
  - Prescaler and ms_cnt are cleared on GO entry.
  - ms_cnt increments on each MS_DIV-cycle prescaler wrap.
  - hit -> DONE; result_ms <= ms_cnt (floor of elapsed ms); result_valid pulses the cycle after hit is sampled (1-cycle latency).
  - ms_cnt reaching TIMEOUT_MS without a hit -> DONE; result_ms=TIMEOUT_MS, timeout=1, result_valid=1.
  - hit in the same cycle ms_cnt reaches TIMEOUT_MS: treated as a hit; result_ms=TIMEOUT_MS, timeout=0.
- DONE: go_led=0; result_ms, foul and timeout hold until the next start.
- start while busy: ignored. hit in IDLE or DONE: ignored.
- sec_en drops when ARM is left, so the divisor counter restarts from 0 each round.
- rst mid-round: immediate return to IDLE with all outputs at reset values.

Optional Feature:
- Macro: REFLEX_BEST_SCORE_EN.
- With it defined:
  - Adds output best_ms[13:0], reset value 14'h3FFF.
  - Updated on a valid non-foul, non-timeout result when result_ms < best_ms, in the same cycle result_valid pulses.
  - Adds output new_best, a one-cycle pulse coincident with that update.
- Without it: neither port exists and no best-score logic is present.

Decomposition:
- Shared package reflex_pkg holds:
  - state enum (IDLE/ARM/GO/DONE);
  - MS_W=14;
  - default TIMEOUT_MS, MS_DIV;
  - LFSR tap constant.
- One natural sub-module: reflex_lfsr16 (clk, rst, seed parameter, q[15:0]). The FSM, prescaler and counters stay in the top block.

Test Plan:
- Timing override for all scenarios: MS_DIV=10, TIMEOUT_MS=50, LFSR seed forced so LFSR[1:0]=2.
- Normal round: start -> sec_en=1. 3 sec_ticks -> go_led=1 next cycle. hit 125 clk after GO entry -> result_ms=12, result_valid pulse 1 cycle later, busy=0.
- False start: start, then hit before the first sec_tick -> foul=1, result_valid pulse, go_led never set, result_ms keeps its previous value.
- Timeout: reach GO, no hit -> after 500 clk result_ms=50, timeout=1, go_led=0.
- Simultaneous events:
  - hit coincident with the final sec_tick -> foul=1.
  - hit coincident with ms_cnt reaching 50 -> result_ms=50, timeout=0.
- Reset and ignore cases:
  - rst asserted in GO -> next cycle all outputs 0, FSM IDLE.
  - start during ARM ignored (wait_cnt unchanged).
- REFLEX_BEST_SCORE_EN: rounds scoring 20, 12, 15 -> best_ms 20, then 12, then 12; new_best pulses on rounds 1 and 2 only.
